zap_cp15_responder: RTL and testbench
=====================================

# zap_cp15_responder

Coprocessor-side responder for the ZAP low-bandwidth coprocessor interface. Accepts the valid/instruction word driven by the predecode coprocessor stage and executes CP15 MRC/MCR against a local 16-entry CP15 register bank. Moves data to and from the CPU register file through a single register port, using mode-aware register translation. Pulses `o_copro_done` to release the CPU-side stall.

## Interface
- `PHY_REGS`, 46: number of physical CPU registers; sets the width of `o_reg_index` to `$clog2(PHY_REGS)`.
- `CP15_ID`, 32'h4107_B360: value returned by reads of c0; writes to c0 are ignored.
- `i_clk`  in  1  clock; single clock domain.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_cp_dav`  in  1  coprocessor request valid; held high by the CPU until it sees done.
- `i_cp_word`  in  32  full coprocessor instruction word.
- `i_cpsr_mode`  in  5  current CPU mode, used for register translation.
- `o_reg_en`  out  1  register-file port enable.
- `o_reg_wr`  out  1  1 = write, 0 = read.
- `o_reg_index`  out  $clog2(PHY_REGS)  translated physical register index.
- `o_reg_wr_data`  out  32  write data to the CPU register.
- `i_reg_rd_data`  in  32  read data; valid one cycle after the read enable.
- `o_copro_done`  out  1  one-cycle completion pulse.
- `o_ctrl`  out  32  c1 contents (control register).
- `o_ttbr`  out  32  c2 contents.
- `o_dac`  out  32  c3 contents.
- `o_cache_inv`  out  1  one-cycle pulse on any MCR to c7.
- `o_tlb_inv`  out  1  one-cycle pulse on any MCR to c8.
- `o_undef`  out  1  undefined-instruction pulse; only present with the macro described under Configuration.

## Operation
- Field decode:
  - CRn = word[19:16], Rd = word[15:12], cp# = word[11:8], L = word[20].
  - MCR/MRC: word[27:24]=4'b1110 and word[4]=1.
  - Anything else (CDP, LDC, STC, or cp# ≠ 15) is unsupported.
- FSM states: IDLE, EXEC, READ, DONE, ACK. Moore outputs, decoded from the state register and the latched word.
- IDLE → EXEC: when `i_cp_dav`=1. Latch `i_cp_word` at that edge.
- EXEC, MRC (L=1):
  - Drive `o_reg_en`=1, `o_reg_wr`=1, `o_reg_index`=translate(Rd, mode), `o_reg_wr_data`=cp15[CRn].
  - Next state DONE.
  - Rd=15: write suppressed (`o_reg_en`=0).
- EXEC, MCR (L=0): drive `o_reg_en`=1, `o_reg_wr`=0, `o_reg_index`=translate(Rd, mode). Next state READ.
- EXEC, unsupported: no port activity. Next state DONE.
- READ:
  - Sample `i_reg_rd_data` into cp15[CRn] at the end of the cycle; CRn=0 is not written.
  - CRn=7 pulses `o_cache_inv`; CRn=8 pulses `o_tlb_inv`. The pulse coincides with the write edge's cycle.
  - Next state DONE.
- DONE: `o_copro_done`=1 for exactly one cycle. Next state ACK.
- ACK: hold until `i_cp_dav`=0, then go to IDLE. This prevents re-triggering on a stale dav.
- Abort: if `i_cp_dav`=0 in EXEC or READ (CPU pipeline clear):
  - Go to IDLE.
  - `o_reg_en` is gated combinationally by `i_cp_dav`.
  - No cp15 update, no invalidate pulse, no done.
- Reset values: all outputs 0; state IDLE; cp15[1..15]=0; c0 reads `CP15_ID`. Async reset mid-transaction discards the transaction.

## Timing
- `i_cp_dav` is sampled high at edge 0.
- MRC: register write in cycle 1; `o_copro_done` in cycle 2.
- MCR: read enable in cycle 1; data sampled in cycle 2; cp15 updated at edge 3; done in cycle 3.
- Unsupported instruction: done in cycle 2.
- Back-to-back: a new request is accepted no earlier than one cycle after `i_cp_dav` is seen low in ACK.
- `o_ctrl`, `o_ttbr` and `o_dac` are direct register outputs; they update the cycle after the write edge.

## Configuration
- `ZAP_CP15_UNDEF_TRAP_EN` defined:
  - Unsupported instructions, and MCR to c0, pulse `o_undef` together with `o_copro_done`.
  - The `o_undef` port exists.
- Macro undefined:
  - `o_undef` is absent.
  - Unsupported instructions complete silently as no-ops with a normal done pulse.

## Structure
- Shared package contents:
  - state enum `cp15_state_t`;
  - CRn index localparams (C0_ID, C1_CTRL, C2_TTBR, C3_DAC, C7_CACHE, C8_TLB);
  - instruction field-position constants;
  - the mode-aware `translate` function shared with the core.
- One natural sub-module, `zap_cp15_regbank`: 16×32 storage with c0 hard-wired to `CP15_ID`, a write port, a combinational read port, and the c1/c2/c3 taps.

## Test plan
- MRC p15,0,r1,c0,c0 in SVC mode → `o_reg_en`=1, `o_reg_wr`=1 and `o_reg_wr_data`=32'h4107_B360 in cycle 1; done in cycle 2.
- MCR p15,0,r2,c1,c0 with `i_reg_rd_data`=32'h0000_1005 → `o_ctrl`=32'h0000_1005 after edge 3; done in cycle 3; ACK holds until dav falls.
- MCR to c7, then to c8 → `o_cache_inv` pulses once, then `o_tlb_inv` pulses once; cp15 contents unchanged apart from the stored word.
- CDP word 32'hEE000F00 → no port activity; done in cycle 2; `o_undef`=1 with the macro, absent without it.
- `i_cp_dav` dropped during READ of an MCR to c2 → `o_ttbr` stays 0, no done, FSM returns to IDLE.
- `i_reset` asserted mid-EXEC → all outputs 0 immediately; next request completes normally.

Source files
------------

// File: rtl/zap_cp15_responder_pkg.sv
// -----------------------------------------------------------------------------
// zap_cp15_responder_pkg
// Shared definitions for the CP15 responder:
//   - cp15_state_t   : responder FSM state
//   - C*_ localparams: CP15 primary register (CRn) indices
//   - field positions of the coprocessor instruction word
//   - CPU mode encodings and the mode-aware translate() function that maps an
//     architectural register number to a physical register-file index
// -----------------------------------------------------------------------------
package zap_cp15_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_READ,
        ST_DONE,
        ST_ACK
    } cp15_state_t;

    // CRn indices
    localparam logic [3:0] C0_ID    = 4'd0;
    localparam logic [3:0] C1_CTRL  = 4'd1;
    localparam logic [3:0] C2_TTBR  = 4'd2;
    localparam logic [3:0] C3_DAC   = 4'd3;
    localparam logic [3:0] C7_CACHE = 4'd7;
    localparam logic [3:0] C8_TLB   = 4'd8;

    // Instruction word field positions
    localparam int unsigned OP_LSB    = 24;   // word[27:24]
    localparam int unsigned L_BIT     = 20;   // word[20]
    localparam int unsigned CRN_LSB   = 16;   // word[19:16]
    localparam int unsigned RD_LSB    = 12;   // word[15:12]
    localparam int unsigned CPNUM_LSB = 8;    // word[11:8]
    localparam int unsigned XFER_BIT  = 4;    // word[4]

    localparam logic [3:0] OP_COPRO_REG = 4'hE;
    localparam logic [3:0] CP15_NUM     = 4'hF;

    // CPU mode encodings
    localparam logic [4:0] MODE_USR = 5'h10;
    localparam logic [4:0] MODE_FIQ = 5'h11;
    localparam logic [4:0] MODE_IRQ = 5'h12;
    localparam logic [4:0] MODE_SVC = 5'h13;
    localparam logic [4:0] MODE_ABT = 5'h17;
    localparam logic [4:0] MODE_UND = 5'h1B;
    localparam logic [4:0] MODE_SYS = 5'h1F;

    // Physical layout: r0..r15 at 0..15, 16 reserved, FIQ r8..r14 at 17..23,
    // then r13/r14 pairs for IRQ (24), SVC (26), UND (28), ABT (30).
    function automatic logic [5:0] translate(input logic [3:0] rd, input logic [4:0] mode);
        logic [5:0] idx;
        idx = {2'b00, rd};
        case (mode)
            MODE_FIQ: if (rd >= 4'd8 && rd <= 4'd14) idx = {2'b00, rd} + 6'd9;
            MODE_IRQ: if (rd == 4'd13) idx = 6'd24; else if (rd == 4'd14) idx = 6'd25;
            MODE_SVC: if (rd == 4'd13) idx = 6'd26; else if (rd == 4'd14) idx = 6'd27;
            MODE_UND: if (rd == 4'd13) idx = 6'd28; else if (rd == 4'd14) idx = 6'd29;
            MODE_ABT: if (rd == 4'd13) idx = 6'd30; else if (rd == 4'd14) idx = 6'd31;
            default:  idx = {2'b00, rd};
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/zap_cp15_responder_regbank.sv
// -----------------------------------------------------------------------------
// zap_cp15_regbank
// 16 x 32 CP15 register storage. c0 is hard-wired to CP15_ID and ignores
// writes; c1..c15 reset to zero.
// Ports:
//   i_clk, i_reset          : clock, asynchronous active-high reset
//   i_we, i_waddr, i_wdata  : synchronous write port
//   i_raddr, o_rdata        : combinational read port
//   o_ctrl, o_ttbr, o_dac   : direct taps of c1, c2, c3
// -----------------------------------------------------------------------------
module zap_cp15_regbank
    import zap_cp15_responder_pkg::*;
#(
    parameter logic [31:0] CP15_ID = 32'h4107_B360
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_we,
    input  logic [3:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_raddr,
    output logic [31:0] o_rdata,
    output logic [31:0] o_ctrl,
    output logic [31:0] o_ttbr,
    output logic [31:0] o_dac
);

    logic [31:0] regs_q [15:1];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned i = 1; i < 16; i++) begin
                regs_q[4'(i)] <= '0;
            end
        end else if (i_we && i_waddr != C0_ID) begin
            regs_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (i_raddr == C0_ID) ? CP15_ID : regs_q[i_raddr];
    assign o_ctrl  = regs_q[C1_CTRL];
    assign o_ttbr  = regs_q[C2_TTBR];
    assign o_dac   = regs_q[C3_DAC];

endmodule

// File: rtl/zap_cp15_responder.sv
// -----------------------------------------------------------------------------
// zap_cp15_responder
// CP15 side of the ZAP coprocessor interface. Executes MRC/MCR to p15 against
// a local register bank, moving data through one CPU register-file port, and
// pulses o_copro_done to release the CPU stall.
// Ports:
//   i_clk, i_reset          : clock, asynchronous active-high reset
//   i_cp_dav, i_cp_word     : request valid (held until done) and instruction
//   i_cpsr_mode             : CPU mode for register translation
//   o_reg_en/wr/index/wr_data, i_reg_rd_data : CPU register-file port
//   o_copro_done            : one-cycle completion pulse
//   o_ctrl, o_ttbr, o_dac   : c1, c2, c3 contents
//   o_cache_inv, o_tlb_inv  : one-cycle pulses on MCR to c7 / c8
//   o_undef                 : only with ZAP_CP15_UNDEF_TRAP_EN defined; pulses
//                             with done for unsupported words and MCR to c0
// -----------------------------------------------------------------------------
module zap_cp15_responder
    import zap_cp15_responder_pkg::*;
#(
    parameter int          PHY_REGS = 46,
    parameter logic [31:0] CP15_ID  = 32'h4107_B360
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_cp_dav,
    input  logic [31:0]                 i_cp_word,
    input  logic [4:0]                  i_cpsr_mode,
    output logic                        o_reg_en,
    output logic                        o_reg_wr,
    output logic [$clog2(PHY_REGS)-1:0] o_reg_index,
    output logic [31:0]                 o_reg_wr_data,
    input  logic [31:0]                 i_reg_rd_data,
    output logic                        o_copro_done,
`ifdef ZAP_CP15_UNDEF_TRAP_EN
    output logic                        o_undef,
`endif
    output logic [31:0]                 o_ctrl,
    output logic [31:0]                 o_ttbr,
    output logic [31:0]                 o_dac,
    output logic                        o_cache_inv,
    output logic                        o_tlb_inv
);

    localparam int unsigned IDX_W = $clog2(PHY_REGS);

    cp15_state_t state_q, state_d;
    logic [31:0] word_q, word_d;

    logic [3:0]  crn, rd, cpnum;
    logic        l_bit, supported;
    logic        bank_we;
    logic [31:0] bank_rdata;
    logic        unused_word_bits;

    assign crn       = word_q[CRN_LSB +: 4];
    assign rd        = word_q[RD_LSB +: 4];
    assign cpnum     = word_q[CPNUM_LSB +: 4];
    assign l_bit     = word_q[L_BIT];
    assign supported = (word_q[OP_LSB +: 4] == OP_COPRO_REG) && word_q[XFER_BIT] &&
                       (cpnum == CP15_NUM);

    assign unused_word_bits = ^{word_q[31:28], word_q[23:21], word_q[7:5], word_q[3:0]};

    zap_cp15_regbank #(
        .CP15_ID (CP15_ID)
    ) u_regbank (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (bank_we),
        .i_waddr (crn),
        .i_wdata (i_reg_rd_data),
        .i_raddr (crn),
        .o_rdata (bank_rdata),
        .o_ctrl  (o_ctrl),
        .o_ttbr  (o_ttbr),
        .o_dac   (o_dac)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        o_reg_en      = 1'b0;
        o_reg_wr      = 1'b0;
        o_reg_index   = '0;
        o_reg_wr_data = '0;
        o_copro_done  = 1'b0;
        o_cache_inv   = 1'b0;
        o_tlb_inv     = 1'b0;
        bank_we       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_cp_dav) begin
                    state_d = ST_EXEC;
                    word_d  = i_cp_word;
                end
            end
            ST_EXEC: begin
                if (!i_cp_dav)                 state_d = ST_IDLE;
                else if (supported && !l_bit)  state_d = ST_READ;
                else                           state_d = ST_DONE;
                if (supported) begin
                    // Enable is gated by dav so a pipeline flush kills the access at once.
                    o_reg_en    = i_cp_dav && (!l_bit || rd != 4'd15);
                    o_reg_wr    = l_bit;
                    o_reg_index = IDX_W'(translate(rd, i_cpsr_mode));
                    if (l_bit) o_reg_wr_data = bank_rdata;
                end
            end
            ST_READ: begin
                if (!i_cp_dav) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d     = ST_DONE;
                    bank_we     = 1'b1;
                    o_cache_inv = (crn == C7_CACHE);
                    o_tlb_inv   = (crn == C8_TLB);
                end
            end
            ST_DONE: begin
                o_copro_done = 1'b1;
                state_d      = ST_ACK;
            end
            ST_ACK: begin
                if (!i_cp_dav) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ZAP_CP15_UNDEF_TRAP_EN
    assign o_undef = (state_q == ST_DONE) && (!supported || (!l_bit && crn == C0_ID));
`endif

endmodule

// File: tb/tb_zap_cp15_responder.sv
module tb_zap_cp15_responder;

    localparam logic [31:0] ID = 32'h4107_B360;

    logic        clk = 1'b0;
    logic        rst;
    logic        dav;
    logic [31:0] word;
    logic [4:0]  mode;
    logic        reg_en, reg_wr;
    logic [5:0]  reg_index;
    logic [31:0] reg_wr_data, reg_rd_data;
    logic        done, cache_inv, tlb_inv;
    logic [31:0] ctrl, ttbr, dac;
`ifdef ZAP_CP15_UNDEF_TRAP_EN
    logic        undef;
`endif

    int vectors    = 0;
    int miscompares = 0;

    // Reference CP15 contents
    logic [31:0] cp15 [16];
    logic [4:0]  modes [7] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};

    always #5 clk = ~clk;

    zap_cp15_responder #(
        .PHY_REGS (46),
        .CP15_ID  (ID)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_cp_dav      (dav),
        .i_cp_word     (word),
        .i_cpsr_mode   (mode),
        .o_reg_en      (reg_en),
        .o_reg_wr      (reg_wr),
        .o_reg_index   (reg_index),
        .o_reg_wr_data (reg_wr_data),
        .i_reg_rd_data (reg_rd_data),
        .o_copro_done  (done),
`ifdef ZAP_CP15_UNDEF_TRAP_EN
        .o_undef       (undef),
`endif
        .o_ctrl        (ctrl),
        .o_ttbr        (ttbr),
        .o_dac         (dac),
        .o_cache_inv   (cache_inv),
        .o_tlb_inv     (tlb_inv)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Banked-register map: FIQ banks r8-r14 from 17; IRQ/SVC/UND/ABT bank r13/r14
    // in consecutive pairs starting at 24.
    function automatic int exp_index(input int r, input logic [4:0] m);
        int bank;
        bank = -1;
        if (m == 5'h11 && r >= 8 && r <= 14) return 17 + (r - 8);
        if (m == 5'h12) bank = 0;
        if (m == 5'h13) bank = 1;
        if (m == 5'h1B) bank = 2;
        if (m == 5'h17) bank = 3;
        if (bank >= 0 && (r == 13 || r == 14)) return 24 + 2 * bank + (r - 13);
        return r;
    endfunction

    function automatic logic [31:0] mk(input bit l, input int crn, input int r, input int cp);
        return {4'hE, 4'hE, 3'b000, l, 4'(crn), 4'(r), 4'(cp), 3'b000, 1'b1, 4'h0};
    endfunction

    task automatic check_taps(input string tag);
        check_eq({tag, ".ctrl"}, ctrl, cp15[1]);
        check_eq({tag, ".ttbr"}, ttbr, cp15[2]);
        check_eq({tag, ".dac"},  dac,  cp15[3]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) cp15[i] = '0;
        cp15[0] = ID;
    endtask

    // One full transaction. abort_at: 0 none, 1 drop dav in EXEC, 2 drop dav in READ.
    task automatic txn(input logic [31:0] w, input logic [4:0] m, input logic [31:0] rdv,
                       input int abort_at, input int ack_hold);
        bit sup, mrc, mcr;
        int crn, r;
        sup = (w[27:24] == 4'hE) && w[4] && (w[11:8] == 4'hF);
        mrc = sup && w[20];
        mcr = sup && !w[20];
        crn = int'(w[19:16]);
        r   = int'(w[15:12]);

        @(negedge clk);
        dav = 1'b1; word = w; mode = m; reg_rd_data = $urandom;
        @(negedge clk);                       // EXEC
        word = $urandom;                      // latched copy must be used from here on
        if (abort_at == 1) begin
            dav = 1'b0;
            #1;
            check_eq("abort_exec.en", reg_en, 0);
            @(negedge clk);
            #1;
            check_eq("abort_exec.done", done, 0);
            check_taps("abort_exec");
            return;
        end
        #1;
        check_eq("exec.en", reg_en, (mrc && r != 15) || mcr);
        check_eq("exec.done", done, 0);
        if (!sup) check_eq("exec.wr", reg_wr, 0);
        if ((mrc && r != 15) || mcr) begin
            check_eq("exec.wr", reg_wr, mrc);
            check_eq("exec.index", 32'(reg_index), exp_index(r, m));
            if (mrc) check_eq("exec.wr_data", reg_wr_data, cp15[crn]);
        end

        if (mcr) begin
            @(negedge clk);                   // READ
            reg_rd_data = rdv;
            if (abort_at == 2) dav = 1'b0;
            #1;
            check_eq("read.en", reg_en, 0);
            check_eq("read.cache_inv", cache_inv, (abort_at != 2) && crn == 7);
            check_eq("read.tlb_inv", tlb_inv, (abort_at != 2) && crn == 8);
            check_eq("read.done", done, 0);
            if (abort_at == 2) begin
                @(negedge clk);
                #1;
                check_eq("abort_read.done", done, 0);
                check_taps("abort_read");
                return;
            end
            if (crn != 0) cp15[crn] = rdv;
        end

        @(negedge clk);                       // DONE
        reg_rd_data = $urandom;
        #1;
        check_eq("done.done", done, 1);
        check_eq("done.en", reg_en, 0);
        check_eq("done.inv", {cache_inv, tlb_inv}, 0);
`ifdef ZAP_CP15_UNDEF_TRAP_EN
        check_eq("done.undef", undef, !sup || (mcr && crn == 0));
`endif
        check_taps("done");
        for (int i = 0; i < ack_hold; i++) begin
            @(negedge clk);
            #1;
            check_eq("ack.done", done, 0);
        end
        @(negedge clk);
        dav = 1'b0;
        #1;
        check_eq("ack_exit.done", done, 0);
        @(negedge clk);
        #1;
        check_eq("idle.en", reg_en, 0);
        check_eq("idle.done", done, 0);
    endtask

    initial begin
        logic [31:0] w;
        int kind, ab;

        rst = 1'b1; dav = 1'b0; word = '0; mode = 5'h13; reg_rd_data = '0;
        model_reset();
        #12;
        check_eq("rst.en", reg_en, 0);
        check_eq("rst.wr", reg_wr, 0);
        check_eq("rst.index", 32'(reg_index), 0);
        check_eq("rst.wr_data", reg_wr_data, 0);
        check_eq("rst.done", done, 0);
        check_eq("rst.inv", {cache_inv, tlb_inv}, 0);
        check_taps("rst");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        txn(mk(1, 0, 1, 15), 5'h13, 0, 0, 0);                  // MRC r1,c0 -> ID
        txn(mk(0, 1, 2, 15), 5'h13, 32'h0000_1005, 0, 2);      // MCR r2,c1
        check_eq("ctrl_1005", ctrl, 32'h0000_1005);
        txn(mk(0, 7, 3, 15), 5'h10, 32'hDEAD_0007, 0, 0);      // cache invalidate
        txn(mk(0, 8, 3, 15), 5'h10, 32'hDEAD_0008, 0, 1);      // TLB invalidate
        txn(32'hEE00_0F00, 5'h10, 0, 0, 0);                    // CDP
        txn(mk(0, 2, 4, 15), 5'h12, 32'h1234_5678, 2, 0);      // abort in READ
        check_eq("ttbr_after_abort", ttbr, 0);
        txn(mk(1, 1, 15, 15), 5'h11, 0, 0, 0);                 // MRC to r15 suppressed
        txn(mk(0, 0, 5, 15), 5'h13, 32'hFFFF_FFFF, 0, 0);      // MCR c0 ignored
        txn(mk(1, 0, 6, 15), 5'h13, 0, 0, 0);                  // c0 still reads ID

        // Async reset in the middle of EXEC
        @(negedge clk);
        dav = 1'b1; word = mk(1, 1, 13, 15); mode = 5'h13;
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("midrst.en", reg_en, 0);
        check_eq("midrst.done", done, 0);
        check_eq("midrst.wr_data", reg_wr_data, 0);
        check_taps("midrst");
        dav = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        txn(mk(0, 3, 14, 15), 5'h1B, 32'hCAFE_F00D, 0, 0);
        txn(mk(1, 3, 14, 15), 5'h17, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            w = $urandom;
            kind = $urandom_range(0, 9);
            if (kind <= 6) begin
                w[27:24] = 4'hE; w[4] = 1'b1; w[11:8] = 4'hF;
            end else if (kind == 7) begin
                w[27:24] = 4'hE; w[4] = 1'b0;                 // CDP
            end else if (kind == 8) begin
                w[27:24] = 4'hE; w[4] = 1'b1;
                w[11:8] = 4'($urandom_range(0, 14));          // other coprocessor
            end else begin
                w[27:24] = 4'hC;                              // LDC/STC space
            end
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
            txn(w, modes[$urandom_range(0, 6)], $urandom, ab, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
